// File: rtl/supermips_trace_pkg.sv
// supermips_trace_pkg: shared types for the retirement trace buffer.
//   inst_class_t    : instruction class produced by inst_classify
//   OPC_* / FN_* / RT_* : MIPS opcode, funct and REGIMM rt field values
//   trace_entry_t   : one queued trace record {pc, word, cls, seq}
package supermips_trace_pkg;

  typedef enum logic [3:0] {
    ALU_R   = 4'd0,
    ALU_I   = 4'd1,
    SHIFT   = 4'd2,
    LUI     = 4'd3,
    LOAD    = 4'd4,
    STORE   = 4'd5,
    BRANCH  = 4'd6,
    JUMP    = 4'd7,
    JREG    = 4'd8,
    UNKNOWN = 4'd9
  } inst_class_t;

  // Primary opcodes (word[31:26])
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_REGIMM  = 6'h01;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_BLEZ    = 6'h06;
  localparam logic [5:0] OPC_BGTZ    = 6'h07;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_SLTIU   = 6'h0B;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LB      = 6'h20;
  localparam logic [5:0] OPC_LH      = 6'h21;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_LBU     = 6'h24;
  localparam logic [5:0] OPC_LHU     = 6'h25;
  localparam logic [5:0] OPC_SB      = 6'h28;
  localparam logic [5:0] OPC_SH      = 6'h29;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  // SPECIAL funct codes (word[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // REGIMM rt codes (word[20:16])
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // Widest sequence number an entry can carry; the top's SEQ_W must not exceed it.
  localparam int SEQ_MAX_W = 32;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          word;
    inst_class_t          cls;
    logic [SEQ_MAX_W-1:0] seq;
  } trace_entry_t;

endpackage

// File: rtl/inst_trace_fifo_classify.sv
// inst_classify: purely combinational MIPS instruction-word classifier.
//   word : 32-bit instruction word
//   cls  : resulting inst_class_t (UNKNOWN for any unrecognised encoding)
module inst_classify
  import supermips_trace_pkg::*;
(
  input  logic [31:0] word,
  output inst_class_t cls
);

  logic [5:0] opc;
  logic [5:0] funct;
  logic [4:0] rt;

  assign opc   = word[31:26];
  assign funct = word[5:0];
  assign rt    = word[20:16];

  always_comb begin
    cls = UNKNOWN;
    case (opc)
      OPC_SPECIAL: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: cls = SHIFT;
          FN_JR, FN_JALR:                                    cls = JREG;
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU:                                   cls = ALU_R;
          default:                                           cls = UNKNOWN;
        endcase
      end
      OPC_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL: cls = BRANCH;
          default:                                cls = UNKNOWN;
        endcase
      end
      OPC_J, OPC_JAL:                          cls = JUMP;
      OPC_BEQ, OPC_BNE, OPC_BLEZ, OPC_BGTZ:    cls = BRANCH;
      OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU,
      OPC_ANDI, OPC_ORI, OPC_XORI:             cls = ALU_I;
      OPC_LUI:                                 cls = LUI;
      OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU: cls = LOAD;
      OPC_SB, OPC_SH, OPC_SW:                  cls = STORE;
      default:                                 cls = UNKNOWN;
    endcase
  end

endmodule

// File: rtl/inst_trace_fifo.sv
// inst_trace_fifo: multi-lane retirement trace buffer.
// Accepts up to LANES retired instructions per cycle, classifies them,
// tags each with a global sequence number and queues them in a DEPTH-entry
// circular FIFO drained one entry per cycle over valid/ready.
//   clock, reset_n         : clock, asynchronous active-low reset
//   flush                  : synchronous clear of FIFO contents
//   in_valid/in_pc/in_word : per-lane retire strobe, PC and instruction word
//   out_valid/out_ready    : head handshake
//   out_pc/out_word/out_class/out_seq : head entry (zero when empty)
//   count                  : occupancy
//   overflow_cnt           : saturating count of dropped instructions
// DEPTH must be a power of two >= max(LANES, 2); SEQ_W must be <= SEQ_MAX_W.
module inst_trace_fifo
  import supermips_trace_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 16,
  parameter int SEQ_W = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES*32-1:0]      in_pc,
  input  logic [LANES*32-1:0]      in_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_word,
  output inst_class_t              out_class,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              overflow_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CNT_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  inst_class_t        lane_cls [LANES];
  logic [CNT_W-1:0]   pos      [LANES];
  logic [CNT_W-1:0]   n_valid;
  logic [CNT_W:0]     room;
  logic               fits;
  logic               push;
  logic               drop;
  logic               pop;

  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;
  logic [SEQ_W-1:0]   seq_q;
  logic [15:0]        ovf_q;

  trace_entry_t       mem [DEPTH];
  trace_entry_t       head;

  // Classification, one classifier per lane
  for (genvar g = 0; g < LANES; g++) begin : g_cls
    inst_classify u_classify (
      .word (in_word[g*32 +: 32]),
      .cls  (lane_cls[g])
    );
  end

  // pos[l] is the number of valid lanes below l: the compacted slot of lane l
  // within the group, so gaps in in_valid leave no hole in the FIFO.
  always_comb begin
    n_valid = '0;
    for (int l = 0; l < LANES; l++) begin
      pos[l]  = n_valid;
      n_valid = n_valid + CNT_W'(in_valid[l]);
    end
  end

  assign pop  = out_valid && out_ready;
  // Free slots after this cycle's pop; the group goes in whole or not at all.
  assign room = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + (CNT_W+1)'(pop);
  assign fits = ({1'b0, n_valid} <= room);
  assign push = fits && !flush;
  // Flushed pushes are discarded silently, not counted as overflow.
  assign drop = !fits && !flush;

  // Control state: pointers, occupancy, sequence and overflow counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
      ovf_q   <= '0;
    end else begin
      // seq advances on every retired instruction so out_seq gaps expose loss
      seq_q <= seq_q + SEQ_W'(n_valid);
      if (drop) begin
        ovf_q <= sat_add16(ovf_q, n_valid);
      end
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (pop) begin
          head_q <= head_q + 1'b1;
        end
        if (push) begin
          tail_q <= tail_q + PTR_W'(n_valid);
        end
        count_q <= count_q + (push ? n_valid : '0) - CNT_W'(pop);
      end
    end
  end

  // Storage write: lane l lands at tail + its compacted slot
  always_ff @(posedge clock) begin
    for (int l = 0; l < LANES; l++) begin
      if (push && in_valid[l]) begin
        mem[tail_q + PTR_W'(pos[l])] <= '{
          pc:   in_pc[l*32 +: 32],
          word: in_word[l*32 +: 32],
          cls:  lane_cls[l],
          seq:  SEQ_MAX_W'(seq_q + SEQ_W'(pos[l]))
        };
      end
    end
  end

  // Head read: outputs are zero whenever the FIFO is empty, including in reset
  assign head         = mem[head_q];
  assign out_valid    = (count_q != '0);
  assign out_pc       = out_valid ? head.pc   : '0;
  assign out_word     = out_valid ? head.word : '0;
  assign out_class    = out_valid ? head.cls  : ALU_R;
  assign out_seq      = out_valid ? head.seq[SEQ_W-1:0] : '0;
  assign count        = count_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_inst_trace_fifo.sv
module tb_inst_trace_fifo;
  import supermips_trace_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              flush = 1'b0;
  logic [1:0]        in_valid = '0;
  logic [63:0]       in_pc = '0;
  logic [63:0]       in_word = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_pc;
  logic [31:0]       out_word;
  inst_class_t       out_class;
  logic [31:0]       out_seq;
  logic [2:0]        count;
  logic [15:0]       overflow_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  inst_trace_fifo #(.LANES(2), .DEPTH(4), .SEQ_W(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_word      (in_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_word     (out_word),
    .out_class    (out_class),
    .out_seq      (out_seq),
    .count        (count),
    .overflow_cnt (overflow_cnt)
  );

  typedef struct {
    logic [1:0]  iv;
    logic [31:0] pc0, w0, pc1, w1;
    logic        rdy, fl;
    logic        ev;
    logic [31:0] epc;
    inst_class_t ecls;
    logic [31:0] eseq;
    logic [2:0]  ecnt;
    logic [15:0] eovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] iv, input logic [31:0] pc0, input logic [31:0] w0,
                              input logic [31:0] pc1, input logic [31:0] w1, input logic rdy,
                              input logic fl, input logic ev, input logic [31:0] epc,
                              input inst_class_t ecls, input logic [31:0] eseq,
                              input logic [2:0] ecnt, input logic [15:0] eovf);
    vec_t v;
    v.iv = iv; v.pc0 = pc0; v.w0 = w0; v.pc1 = pc1; v.w1 = w1; v.rdy = rdy; v.fl = fl;
    v.ev = ev; v.epc = epc; v.ecls = ecls; v.eseq = eseq; v.ecnt = ecnt; v.eovf = eovf;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Two-lane push, drain
    vecs.push_back(mk(2'b11, 'h100, 'h00851020, 'h104, 'h8C430004, 1, 0, 1, 'h100, ALU_R, 0, 2, 0));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 1, 'h104, LOAD, 1, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, ALU_R, 0, 0, 0));
    // Lane gap
    vecs.push_back(mk(2'b10, 0, 0, 'h108, 'h3C01ABCD, 0, 0, 1, 'h108, LUI, 2, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, ALU_R, 0, 0, 0));
    // Classification sweep: push one per cycle, pop previous
    vecs.push_back(mk(2'b01, 'h500, 'h00000000, 0, 0, 1, 0, 1, 'h500, SHIFT,   3, 1, 0));
    vecs.push_back(mk(2'b01, 'h504, 'h03E00008, 0, 0, 1, 0, 1, 'h504, JREG,    4, 1, 0));
    vecs.push_back(mk(2'b01, 'h508, 'h0000000C, 0, 0, 1, 0, 1, 'h508, UNKNOWN, 5, 1, 0));
    vecs.push_back(mk(2'b01, 'h50C, 'h04110010, 0, 0, 1, 0, 1, 'h50C, BRANCH,  6, 1, 0));
    vecs.push_back(mk(2'b01, 'h510, 'h04050000, 0, 0, 1, 0, 1, 'h510, UNKNOWN, 7, 1, 0));
    vecs.push_back(mk(2'b01, 'h514, 'h0C000040, 0, 0, 1, 0, 1, 'h514, JUMP,    8, 1, 0));
    vecs.push_back(mk(2'b01, 'h518, 'h1000FFFF, 0, 0, 1, 0, 1, 'h518, BRANCH,  9, 1, 0));
    vecs.push_back(mk(2'b01, 'h51C, 'h2408000A, 0, 0, 1, 0, 1, 'h51C, ALU_I,  10, 1, 0));
    vecs.push_back(mk(2'b01, 'h520, 'hAC430004, 0, 0, 1, 0, 1, 'h520, STORE,  11, 1, 0));
    vecs.push_back(mk(2'b01, 'h524, 'hFC000000, 0, 0, 1, 0, 1, 'h524, UNKNOWN,12, 1, 0));
    vecs.push_back(mk(2'b01, 'h528, 'h0000002A, 0, 0, 1, 0, 1, 'h528, ALU_R,  13, 1, 0));
    vecs.push_back(mk(2'b01, 'h52C, 'h38000000, 0, 0, 1, 0, 1, 'h52C, ALU_I,  14, 1, 0));
    vecs.push_back(mk(2'b01, 'h530, 'h88000000, 0, 0, 1, 0, 1, 'h530, UNKNOWN,15, 1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, ALU_R, 0, 0, 0));
    // Overflow: three groups into a 4-deep FIFO with no drain
    vecs.push_back(mk(2'b11, 'h200, 'h00851020, 'h204, 'h00851020, 0, 0, 1, 'h200, ALU_R, 16, 2, 0));
    vecs.push_back(mk(2'b11, 'h208, 'h00851020, 'h20C, 'h00851020, 0, 0, 1, 'h200, ALU_R, 16, 4, 0));
    vecs.push_back(mk(2'b11, 'h210, 'h00851020, 'h214, 'h00851020, 0, 0, 1, 'h200, ALU_R, 16, 4, 2));
    // Full with pop: one lane fits, two lanes dropped
    vecs.push_back(mk(2'b01, 'h218, 'h8C430004, 0, 0, 1, 0, 1, 'h204, ALU_R, 17, 4, 2));
    vecs.push_back(mk(2'b11, 'h21C, 'h00851020, 'h220, 'h00851020, 1, 0, 1, 'h208, ALU_R, 18, 3, 4));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 1, 'h20C, ALU_R, 19, 2, 4));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 1, 'h218, LOAD,  22, 1, 4));
    // Unknown enqueued, then flush with same-cycle push and pop
    vecs.push_back(mk(2'b01, 'h300, 'hFC000000, 0, 0, 0, 0, 1, 'h218, LOAD, 22, 2, 4));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 1, 'h300, UNKNOWN, 25, 1, 4));
    vecs.push_back(mk(2'b11, 'h304, 'h00851020, 'h308, 'h00851020, 0, 0, 1, 'h300, UNKNOWN, 25, 3, 4));
    vecs.push_back(mk(2'b11, 'h30C, 'h00851020, 'h310, 'h00851020, 1, 1, 0, 0, ALU_R, 0, 0, 4));
    vecs.push_back(mk(2'b01, 'h400, 'h00851020, 0, 0, 0, 0, 1, 'h400, ALU_R, 30, 1, 4));

    // Reset and idle
    #1 reset_n = 1'b0;
    #1;
    chk("reset_valid", 64'(out_valid), 0);
    chk("reset_count", 64'(count), 0);
    chk("reset_ovf",   64'(overflow_cnt), 0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    chk("idle_valid", 64'(out_valid), 0);
    chk("idle_count", 64'(count), 0);
    chk("idle_ovf",   64'(overflow_cnt), 0);

    foreach (vecs[i]) begin
      in_valid  = vecs[i].iv;
      in_pc     = {vecs[i].pc1, vecs[i].pc0};
      in_word   = {vecs[i].w1, vecs[i].w0};
      out_ready = vecs[i].rdy;
      flush     = vecs[i].fl;
      @(posedge clock); #1;
      chk($sformatf("v%0d_valid", i), 64'(out_valid),    64'(vecs[i].ev));
      chk($sformatf("v%0d_pc", i),    64'(out_pc),       64'(vecs[i].epc));
      chk($sformatf("v%0d_class", i), 64'(out_class),    64'(vecs[i].ecls));
      chk($sformatf("v%0d_seq", i),   64'(out_seq),      64'(vecs[i].eseq));
      chk($sformatf("v%0d_count", i), 64'(count),        64'(vecs[i].ecnt));
      chk($sformatf("v%0d_ovf", i),   64'(overflow_cnt), 64'(vecs[i].eovf));
    end
    in_valid = '0; flush = 1'b0; out_ready = 1'b0;

    // Asynchronous reset mid-drain, away from any clock edge
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_count", 64'(count), 0);
    chk("mid_rst_ovf",   64'(overflow_cnt), 0);
    chk("mid_rst_pc",    64'(out_pc), 0);
    chk("mid_rst_seq",   64'(out_seq), 0);
    #2 reset_n = 1'b1;
    in_valid = 2'b01;
    in_pc    = {32'h0, 32'h600};
    in_word  = {32'h0, 32'h8C430004};
    @(posedge clock); #1;
    chk("post_rst_seq",   64'(out_seq), 0);
    chk("post_rst_count", 64'(count), 1);
    chk("post_rst_class", 64'(out_class), 64'(LOAD));
    chk("post_rst_pc",    64'(out_pc), 'h600);

    // Overflow saturation: first group fits (count 3), every later group drops 2
    in_valid = 2'b11;
    in_pc    = {32'h704, 32'h700};
    in_word  = {32'h00851020, 32'h00851020};
    repeat (2) @(posedge clock);
    #1;
    chk("sat_ovf_first", 64'(overflow_cnt), 2);
    chk("sat_count",     64'(count), 3);
    repeat (32766) @(posedge clock);
    #1;
    chk("sat_ovf_below", 64'(overflow_cnt), 'hFFFE);
    @(posedge clock); #1;
    chk("sat_ovf_clip",  64'(overflow_cnt), 'hFFFF);
    @(posedge clock); #1;
    chk("sat_ovf_hold",  64'(overflow_cnt), 'hFFFF);
    chk("sat_head_pc",   64'(out_pc), 'h600);
    in_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
